// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter
// Shares the register file's single write port between two writeback requesters
// (0: ALU, 1: load/memory). Each requester pushes into its own FIFO through a
// valid/ready handshake. A round-robin arbiter pops at most one FIFO head per
// cycle into registered write-port outputs. Writes aimed at register 0 are
// handshaken and dropped.
//
// Ports
//   iClk, iRst_n                 clock, asynchronous active-low reset
//   iValidN/iAddrN/iDataN        requester N write request (N = 0, 1)
//   oReadyN                      requester N FIFO can accept
//   oAddrWrite/oDataWrite        registered write address / data to register file
//   oEnWrite                     registered write enable, one cycle per write
//   oCount0/oCount1              FIFO occupancy
//   oIdle                        both FIFOs empty and no write in flight
module rf_write_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned CNT_WIDTH  = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  iClk,
  input  logic                  iRst_n,
  input  logic                  iValid0,
  input  logic [ADDR_WIDTH-1:0] iAddr0,
  input  logic [DATA_WIDTH-1:0] iData0,
  output logic                  oReady0,
  input  logic                  iValid1,
  input  logic [ADDR_WIDTH-1:0] iAddr1,
  input  logic [DATA_WIDTH-1:0] iData1,
  output logic                  oReady1,
  output logic [ADDR_WIDTH-1:0] oAddrWrite,
  output logic [DATA_WIDTH-1:0] oDataWrite,
  output logic                  oEnWrite,
  output logic [CNT_WIDTH-1:0]  oCount0,
  output logic [CNT_WIDTH-1:0]  oCount1,
  output logic                  oIdle
);

  localparam int unsigned          PtrWidth = $clog2(FIFO_DEPTH);
  localparam logic [CNT_WIDTH-1:0] DepthCnt = CNT_WIDTH'(FIFO_DEPTH);

  logic [ADDR_WIDTH-1:0] addrMem [2][FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] dataMem [2][FIFO_DEPTH];
  logic [PtrWidth-1:0]   wrPtr   [2];
  logic [PtrWidth-1:0]   rdPtr   [2];
  logic [CNT_WIDTH-1:0]  count   [2];
  logic                  prio;  // requester that wins when both heads are present

  logic [ADDR_WIDTH-1:0] inAddr [2];
  logic [DATA_WIDTH-1:0] inData [2];
  logic [1:0]            inValid;
  logic [1:0]            ready;
  logic [1:0]            empty;
  logic [1:0]            push;
  logic [1:0]            pop;

  assign inAddr[0]  = iAddr0;
  assign inAddr[1]  = iAddr1;
  assign inData[0]  = iData0;
  assign inData[1]  = iData1;
  assign inValid[0] = iValid0;
  assign inValid[1] = iValid1;

  always_comb begin
    ready = '0;
    empty = '0;
    push  = '0;
    for (int n = 0; n < 2; n++) begin
      // Ready is held low during reset so nothing is accepted while state is cleared.
      ready[n] = iRst_n && (count[n] < DepthCnt);
      empty[n] = (count[n] == '0);
      // Register-0 writes complete the handshake but are never stored.
      push[n]  = inValid[n] && ready[n] && (inAddr[n] != '0);
    end
    pop    = '0;
    pop[0] = !empty[0] && (empty[1] || !prio);
    pop[1] = !empty[1] && (empty[0] || prio);
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge iClk) begin
    for (int n = 0; n < 2; n++) begin
      if (push[n]) begin
        addrMem[n][wrPtr[n]] <= inAddr[n];
        dataMem[n][wrPtr[n]] <= inData[n];
      end
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      for (int n = 0; n < 2; n++) begin
        wrPtr[n] <= '0;
        rdPtr[n] <= '0;
        count[n] <= '0;
      end
      prio       <= 1'b0;
      oEnWrite   <= 1'b0;
      oAddrWrite <= '0;
      oDataWrite <= '0;
    end else begin
      for (int n = 0; n < 2; n++) begin
        if (push[n]) wrPtr[n] <= wrPtr[n] + PtrWidth'(1);
        if (pop[n])  rdPtr[n] <= rdPtr[n] + PtrWidth'(1);
        if (push[n] && !pop[n]) begin
          count[n] <= count[n] + CNT_WIDTH'(1);
        end else if (pop[n] && !push[n]) begin
          count[n] <= count[n] - CNT_WIDTH'(1);
        end
      end
      // Address/data hold their last value when nothing is granted.
      if (pop[0]) begin
        oAddrWrite <= addrMem[0][rdPtr[0]];
        oDataWrite <= dataMem[0][rdPtr[0]];
      end else if (pop[1]) begin
        oAddrWrite <= addrMem[1][rdPtr[1]];
        oDataWrite <= dataMem[1][rdPtr[1]];
      end
      oEnWrite <= |pop;
      // Priority passes to the requester that was not just served.
      if (|pop) prio <= pop[0];
    end
  end

  assign oReady0 = ready[0];
  assign oReady1 = ready[1];
  assign oCount0 = count[0];
  assign oCount1 = count[1];
  assign oIdle   = empty[0] && empty[1] && !oEnWrite;

endmodule

// File: tb/tb_rf_write_arbiter.sv
module tb_rf_write_arbiter;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 2;
  localparam int CW    = 2;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } ent_t;

  logic          iClk;
  logic          iRst_n;
  logic          iValid0, iValid1;
  logic [AW-1:0] iAddr0, iAddr1;
  logic [DW-1:0] iData0, iData1;
  logic          oReady0, oReady1;
  logic [AW-1:0] oAddrWrite;
  logic [DW-1:0] oDataWrite;
  logic          oEnWrite;
  logic [CW-1:0] oCount0, oCount1;
  logic          oIdle;

  rf_write_arbiter #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .FIFO_DEPTH(DEPTH),
    .CNT_WIDTH (CW)
  ) dut (
    .iClk      (iClk),
    .iRst_n    (iRst_n),
    .iValid0   (iValid0),
    .iAddr0    (iAddr0),
    .iData0    (iData0),
    .oReady0   (oReady0),
    .iValid1   (iValid1),
    .iAddr1    (iAddr1),
    .iData1    (iData1),
    .oReady1   (oReady1),
    .oAddrWrite(oAddrWrite),
    .oDataWrite(oDataWrite),
    .oEnWrite  (oEnWrite),
    .oCount0   (oCount0),
    .oCount1   (oCount1),
    .oIdle     (oIdle)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  int total = 0;
  int bad   = 0;

  // Reference model: two queues, a round-robin flag and the last issued write.
  ent_t          q0[$];
  ent_t          q1[$];
  bit            mPrio;
  logic          mEn;
  logic [AW-1:0] mAddr;
  logic [DW-1:0] mData;
  bit            acc0, acc1;

  task automatic model_clear();
    q0.delete();
    q1.delete();
    mPrio = 1'b0;
    mEn   = 1'b0;
    mAddr = '0;
    mData = '0;
  endtask

  // Drive one cycle of requests, advance the model across the edge, settle at edge+1.
  task automatic tick(input bit v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                      input bit v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    int   g;
    ent_t e;
    iValid0 = v0; iAddr0 = a0; iData0 = d0;
    iValid1 = v1; iAddr1 = a1; iData1 = d1;
    acc0 = v0 && (q0.size() < DEPTH);
    acc1 = v1 && (q1.size() < DEPTH);
    g = 2;
    if (q0.size() != 0 && (q1.size() == 0 || !mPrio)) g = 0;
    else if (q1.size() != 0) g = 1;
    @(posedge iClk);
    mEn = 1'b0;
    if (g == 0) begin
      e = q0.pop_front(); mAddr = e.addr; mData = e.data; mEn = 1'b1; mPrio = 1'b1;
    end else if (g == 1) begin
      e = q1.pop_front(); mAddr = e.addr; mData = e.data; mEn = 1'b1; mPrio = 1'b0;
    end
    if (acc0 && a0 != '0) q0.push_back('{addr: a0, data: d0});
    if (acc1 && a1 != '0) q1.push_back('{addr: a1, data: d1});
    #1;
  endtask

  task automatic idle_tick();
    tick(1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  // Reset pulse placed between clock edges.
  task automatic pulse_reset();
    @(negedge iClk);
    iValid0 = 1'b0;
    iValid1 = 1'b0;
    iRst_n  = 1'b0;
    #1;
    model_clear();
    iRst_n  = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    iRst_n = 1'b0;
    iValid0 = 1'b0; iAddr0 = '0; iData0 = '0;
    iValid1 = 1'b0; iAddr1 = '0; iData1 = '0;
    model_clear();
    #3;
    total++; if (oEnWrite !== 1'b0) begin bad++; $display("FAIL rst_en got=%b exp=0", oEnWrite); end
    total++; if (oAddrWrite !== '0) begin bad++; $display("FAIL rst_addr got=%0d exp=0", oAddrWrite); end
    total++; if (oDataWrite !== '0) begin bad++; $display("FAIL rst_data got=%h exp=0", oDataWrite); end
    total++; if (oCount0 !== '0 || oCount1 !== '0) begin
      bad++; $display("FAIL rst_count got=%0d/%0d exp=0/0", oCount0, oCount1);
    end
    total++; if (oReady0 !== 1'b0 || oReady1 !== 1'b0) begin
      bad++; $display("FAIL rst_ready got=%b/%b exp=0/0", oReady0, oReady1);
    end
    total++; if (oIdle !== 1'b1) begin bad++; $display("FAIL rst_idle got=%b exp=1", oIdle); end
    repeat (2) @(posedge iClk);
    @(negedge iClk);
    iRst_n = 1'b1;
    #1;
    total++; if (oReady0 !== 1'b1 || oReady1 !== 1'b1) begin
      bad++; $display("FAIL rel_ready got=%b/%b exp=1/1", oReady0, oReady1);
    end
    total++; if (oIdle !== 1'b1 || oEnWrite !== 1'b0) begin
      bad++; $display("FAIL rel_idle got idle=%b en=%b exp idle=1 en=0", oIdle, oEnWrite);
    end
  endtask

  task automatic test_single_write();
    tick(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0);
    total++; if (oEnWrite !== 1'b0 || oCount0 !== 2'd1) begin
      bad++; $display("FAIL single_t got en=%b cnt=%0d exp en=0 cnt=1", oEnWrite, oCount0);
    end
    idle_tick();
    total++; if (oEnWrite !== 1'b1 || oAddrWrite !== 5'd5 || oDataWrite !== 32'hDEADBEEF) begin
      bad++; $display("FAIL single_t1 got en=%b a=%0d d=%h exp en=1 a=5 d=deadbeef",
                      oEnWrite, oAddrWrite, oDataWrite);
    end
    idle_tick();
    total++; if (oEnWrite !== 1'b0 || oIdle !== 1'b1) begin
      bad++; $display("FAIL single_t2 got en=%b idle=%b exp en=0 idle=1", oEnWrite, oIdle);
    end
  endtask

  task automatic test_contention();
    logic [AW-1:0] ea [5];
    logic [DW-1:0] ed [5];
    pulse_reset();
    tick(1'b1, 5'd3, 32'h11, 1'b1, 5'd7, 32'h22);
    idle_tick(); ea[0] = oAddrWrite; ed[0] = oDataWrite;
    total++; if (oEnWrite !== 1'b1 || ea[0] !== 5'd3 || ed[0] !== 32'h11) begin
      bad++; $display("FAIL cont_first got en=%b a=%0d d=%h exp a=3 d=11", oEnWrite, ea[0], ed[0]);
    end
    idle_tick(); ea[1] = oAddrWrite; ed[1] = oDataWrite;
    total++; if (oEnWrite !== 1'b1 || ea[1] !== 5'd7 || ed[1] !== 32'h22) begin
      bad++; $display("FAIL cont_second got en=%b a=%0d d=%h exp a=7 d=22", oEnWrite, ea[1], ed[1]);
    end
    // A lone requester-0 write hands priority to requester 1.
    tick(1'b1, 5'd6, 32'h55, 1'b0, '0, '0);
    idle_tick(); ea[2] = oAddrWrite; ed[2] = oDataWrite;
    total++; if (oEnWrite !== 1'b1 || ea[2] !== 5'd6 || ed[2] !== 32'h55) begin
      bad++; $display("FAIL cont_solo got en=%b a=%0d d=%h exp a=6 d=55", oEnWrite, ea[2], ed[2]);
    end
    tick(1'b1, 5'd4, 32'h33, 1'b1, 5'd8, 32'h44);
    idle_tick(); ea[3] = oAddrWrite; ed[3] = oDataWrite;
    total++; if (oEnWrite !== 1'b1 || ea[3] !== 5'd8 || ed[3] !== 32'h44) begin
      bad++; $display("FAIL cont_pair2a got en=%b a=%0d d=%h exp a=8 d=44", oEnWrite, ea[3], ed[3]);
    end
    idle_tick(); ea[4] = oAddrWrite; ed[4] = oDataWrite;
    total++; if (oEnWrite !== 1'b1 || ea[4] !== 5'd4 || ed[4] !== 32'h33) begin
      bad++; $display("FAIL cont_pair2b got en=%b a=%0d d=%h exp a=4 d=33", oEnWrite, ea[4], ed[4]);
    end
    idle_tick();
  endtask

  task automatic test_backpressure();
    int sent0 = 0;
    int sent1 = 0;
    int got1  = 0;
    bit sawFull = 1'b0;
    for (int c = 0; c < 30; c++) begin
      tick(c < 16, 5'(9 + sent0), 32'(c), sent1 < 4, 5'(1 + sent1), 32'h100 + 32'(sent1));
      if (acc0) sent0++;
      if (acc1) sent1++;
      total++; if (oCount0 !== CW'(q0.size()) || oCount1 !== CW'(q1.size())) begin
        bad++; $display("FAIL bp_count c=%0d got=%0d/%0d exp=%0d/%0d", c, oCount0, oCount1,
                        q0.size(), q1.size());
      end
      total++; if (oCount0 > 2'd2 || oCount1 > 2'd2) begin
        bad++; $display("FAIL bp_bound c=%0d got=%0d/%0d exp<=2", c, oCount0, oCount1);
      end
      total++; if (oEnWrite !== mEn || (mEn && oAddrWrite !== mAddr)) begin
        bad++; $display("FAIL bp_issue c=%0d got en=%b a=%0d exp en=%b a=%0d", c, oEnWrite,
                        oAddrWrite, mEn, mAddr);
      end
      if (oCount1 == 2'd2 && oReady1 === 1'b0) sawFull = 1'b1;
      if (oEnWrite === 1'b1 && oAddrWrite >= 5'd1 && oAddrWrite <= 5'd4) begin
        total++; if (oAddrWrite !== 5'(got1 + 1) || oDataWrite !== 32'h100 + 32'(got1)) begin
          bad++; $display("FAIL bp_r1_order got a=%0d d=%h exp a=%0d d=%h", oAddrWrite, oDataWrite,
                          got1 + 1, 32'h100 + 32'(got1));
        end
        got1++;
      end
    end
    total++; if (got1 !== 4) begin bad++; $display("FAIL bp_r1_total got=%0d exp=4", got1); end
    total++; if (sawFull !== 1'b1) begin bad++; $display("FAIL bp_full got=0 exp=1"); end
  endtask

  task automatic test_reg0_discard();
    int pulses = 0;
    tick(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, '0, '0);
    total++; if (oCount0 !== 2'd0 || oEnWrite !== 1'b0) begin
      bad++; $display("FAIL r0_count got cnt=%0d en=%b exp cnt=0 en=0", oCount0, oEnWrite);
    end
    tick(1'b1, 5'd2, 32'h5, 1'b0, '0, '0);
    total++; if (oCount0 !== 2'd1) begin bad++; $display("FAIL r0_cnt2 got=%0d exp=1", oCount0); end
    for (int c = 0; c < 4; c++) begin
      idle_tick();
      if (oEnWrite === 1'b1) begin
        pulses++;
        total++; if (oAddrWrite !== 5'd2 || oDataWrite !== 32'h5) begin
          bad++; $display("FAIL r0_write got a=%0d d=%h exp a=2 d=5", oAddrWrite, oDataWrite);
        end
      end
    end
    total++; if (pulses !== 1) begin bad++; $display("FAIL r0_pulses got=%0d exp=1", pulses); end
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 6; c++) begin
      tick(1'b1, 5'(c + 10), 32'($urandom), 1'b1, 5'(c + 20), 32'($urandom));
    end
    iValid0 = 1'b0;
    iValid1 = 1'b0;
    iRst_n  = 1'b0;
    #1;
    total++; if (oEnWrite !== 1'b0 || oCount0 !== '0 || oCount1 !== '0) begin
      bad++; $display("FAIL mid_assert got en=%b cnt=%0d/%0d exp 0 0/0", oEnWrite, oCount0, oCount1);
    end
    total++; if (oReady0 !== 1'b0 || oReady1 !== 1'b0 || oIdle !== 1'b1) begin
      bad++; $display("FAIL mid_ready got rdy=%b/%b idle=%b exp 0/0 1", oReady0, oReady1, oIdle);
    end
    model_clear();
    #1;
    iRst_n = 1'b1;
    #1;
    total++; if (oReady0 !== 1'b1 || oReady1 !== 1'b1) begin
      bad++; $display("FAIL mid_release got=%b/%b exp=1/1", oReady0, oReady1);
    end
    for (int c = 0; c < 3; c++) begin
      idle_tick();
      total++; if (oEnWrite !== 1'b0) begin bad++; $display("FAIL mid_stale c=%0d got=1 exp=0", c); end
    end
    tick(1'b0, '0, '0, 1'b1, 5'd12, 32'hABCD);
    total++; if (oEnWrite !== 1'b0) begin bad++; $display("FAIL mid_new_t got=1 exp=0"); end
    idle_tick();
    total++; if (oEnWrite !== 1'b1 || oAddrWrite !== 5'd12 || oDataWrite !== 32'hABCD) begin
      bad++; $display("FAIL mid_new_t1 got en=%b a=%0d d=%h exp en=1 a=12 d=abcd", oEnWrite,
                      oAddrWrite, oDataWrite);
    end
    idle_tick();
  endtask

  task automatic test_random();
    logic [AW-1:0] a0, a1;
    for (int c = 0; c < 400; c++) begin
      a0 = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom);
      a1 = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom);
      tick($urandom_range(0, 2) != 0, a0, $urandom, $urandom_range(0, 2) != 0, a1, $urandom);
      total++; if (oEnWrite !== mEn) begin
        bad++; $display("FAIL rnd_en c=%0d got=%b exp=%b", c, oEnWrite, mEn);
      end
      total++; if (oAddrWrite !== mAddr || oDataWrite !== mData) begin
        bad++; $display("FAIL rnd_wr c=%0d got a=%0d d=%h exp a=%0d d=%h", c, oAddrWrite,
                        oDataWrite, mAddr, mData);
      end
      total++; if (oCount0 !== CW'(q0.size()) || oCount1 !== CW'(q1.size())) begin
        bad++; $display("FAIL rnd_cnt c=%0d got=%0d/%0d exp=%0d/%0d", c, oCount0, oCount1,
                        q0.size(), q1.size());
      end
      total++; if (oReady0 !== (q0.size() < DEPTH) || oReady1 !== (q1.size() < DEPTH)) begin
        bad++; $display("FAIL rnd_ready c=%0d got=%b/%b exp=%b/%b", c, oReady0, oReady1,
                        q0.size() < DEPTH, q1.size() < DEPTH);
      end
      total++; if (oIdle !== (q0.size() == 0 && q1.size() == 0 && !mEn)) begin
        bad++; $display("FAIL rnd_idle c=%0d got=%b", c, oIdle);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_contention();
    test_backpressure();
    test_reg0_discard();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
